// File: rtl/mac_sequencer.sv
// Dot-product job controller: clears the MAC, streams LEN weight/data pairs into it
// with one-cycle enables, then captures and holds the final accumulation.
module mac_sequencer #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_START,
  input  logic [LEN_WIDTH-1:0]    i_LEN,
  output logic                    o_BUSY,
  input  logic                    i_VALID,
  input  logic [INPUT_WIDTH-1:0]  i_WEIGHT,
  input  logic [INPUT_WIDTH-1:0]  i_DATA,
  output logic                    o_READY,
  output logic                    o_MAC_CLR,
  output logic                    o_MAC_EN,
  output logic [INPUT_WIDTH-1:0]  o_WEIGHT,
  output logic [INPUT_WIDTH-1:0]  o_DATA,
  input  logic [OUTPUT_WIDTH-1:0] i_ACCUMULATE,
  output logic [OUTPUT_WIDTH-1:0] o_RESULT,
  output logic                    o_RESULT_VALID,
  input  logic                    i_RESULT_READY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [LEN_WIDTH-1:0]    remaining_reg, remaining_next;
  logic [INPUT_WIDTH-1:0]  weight_reg, weight_next;
  logic [INPUT_WIDTH-1:0]  data_reg, data_next;
  logic                    mac_en_reg, mac_en_next;
  logic [OUTPUT_WIDTH-1:0] result_reg, result_next;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_reg     <= S_IDLE;
      remaining_reg <= '0;
      weight_reg    <= '0;
      data_reg      <= '0;
      mac_en_reg    <= 1'b0;
      result_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      weight_reg    <= weight_next;
      data_reg      <= data_next;
      mac_en_reg    <= mac_en_next;
      result_reg    <= result_next;
    end
  end

  // Operands and enable default to zero so the MAC only ever sees a pair for the
  // single cycle following its acceptance.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    weight_next    = '0;
    data_next      = '0;
    mac_en_next    = 1'b0;
    result_next    = result_reg;
    case (state_reg)
      S_IDLE: begin
        if (i_START) begin
          remaining_next = i_LEN;
          state_next     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (remaining_reg == '0) begin
          result_next = '0;
          state_next  = S_DONE;
        end else begin
          state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (i_VALID) begin
          weight_next    = i_WEIGHT;
          data_next      = i_DATA;
          mac_en_next    = 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == LEN_WIDTH'(1)) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The accumulate input already folds in the last pair presented this cycle.
        result_next = i_ACCUMULATE;
        state_next  = S_DONE;
      end
      S_DONE: begin
        if (i_RESULT_READY) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign o_BUSY         = (state_reg != S_IDLE);
  assign o_READY        = (state_reg == S_STREAM);
  assign o_MAC_CLR      = (state_reg == S_CLEAR);
  assign o_MAC_EN       = mac_en_reg;
  assign o_WEIGHT       = weight_reg;
  assign o_DATA         = data_reg;
  assign o_RESULT       = result_reg;
  assign o_RESULT_VALID = (state_reg == S_DONE);

endmodule

// File: tb/tb_mac_sequencer.sv
// Random and directed dot-product jobs against two sequencers (32- and 16-bit results),
// each driving a behavioural MAC; expected results come from plain sums of products.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        valid;
  logic [7:0]  weight, data;
  logic        result_ready;

  logic        busy32, ready32, clr32, en32, rvalid32;
  logic [7:0]  w32, d32;
  logic [31:0] acc32, result32, sum32;
  logic        busy16, ready16, clr16, en16, rvalid16;
  logic [7:0]  w16, d16;
  logic [15:0] acc16, result16, sum16;

  int n_tests = 0;
  int n_fail  = 0;
  int job_id  = 0;
  logic [7:0] w_arr [0:255];
  logic [7:0] d_arr [0:255];

  always #5 clk = ~clk;

  mac_sequencer #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32), .LEN_WIDTH(8)) u_seq32 (
    .i_CLK(clk), .i_RST(rst), .i_START(start), .i_LEN(len), .o_BUSY(busy32),
    .i_VALID(valid), .i_WEIGHT(weight), .i_DATA(data), .o_READY(ready32),
    .o_MAC_CLR(clr32), .o_MAC_EN(en32), .o_WEIGHT(w32), .o_DATA(d32),
    .i_ACCUMULATE(acc32), .o_RESULT(result32), .o_RESULT_VALID(rvalid32),
    .i_RESULT_READY(result_ready)
  );

  mac_sequencer #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .LEN_WIDTH(8)) u_seq16 (
    .i_CLK(clk), .i_RST(rst), .i_START(start), .i_LEN(len), .o_BUSY(busy16),
    .i_VALID(valid), .i_WEIGHT(weight), .i_DATA(data), .o_READY(ready16),
    .o_MAC_CLR(clr16), .o_MAC_EN(en16), .o_WEIGHT(w16), .o_DATA(d16),
    .i_ACCUMULATE(acc16), .o_RESULT(result16), .o_RESULT_VALID(rvalid16),
    .i_RESULT_READY(result_ready)
  );

  // Behavioural MACs: registered sum, combinational sum + product; not touched by reset.
  always @(posedge clk) begin
    if (clr32) sum32 <= '0;
    else if (en32) sum32 <= sum32 + 32'(w32) * 32'(d32);
    if (clr16) sum16 <= '0;
    else if (en16) sum16 <= sum16 + 16'(w16) * 16'(d16);
  end
  assign acc32 = sum32 + 32'(w32) * 32'(d32);
  assign acc16 = sum16 + 16'(w16) * 16'(d16);

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s job=%0d got=%0d expected=%0d", tag, job_id, got, exp);
    end
  endtask

  // Called right after a falling edge; start is driven immediately.
  // gap_n < 0 gives random bubbles, otherwise exactly gap_n idle cycles between pairs.
  task automatic run_job(input int n, input int gap_n, input int hold);
    longint dot = 0;
    int     idx = 0, gap_cnt, en_seen = 0, guard = 0;
    bit     give;
    logic   exp_en = 1'b0;
    logic [7:0] exp_w = '0, exp_d = '0;
    longint exp32, exp16;

    job_id++;
    for (int i = 0; i < n; i++) dot += longint'(w_arr[i]) * longint'(d_arr[i]);
    exp32 = dot & 64'hFFFF_FFFF;
    exp16 = dot & 64'hFFFF;

    start = 1'b1; len = 8'(n);
    @(negedge clk);
    start = 1'b0; len = 8'($urandom);
    check("clear_pulse", clr32, 1);
    check("clear_no_ready", ready32, 0);
    check("clear_busy", busy32, 1);
    @(negedge clk);
    check("clr_single", clr32, 0);

    if (n == 0) begin
      check("zero_no_ready", ready32, 0);
    end else begin
      gap_cnt = (gap_n < 0) ? 0 : gap_n;
      while (idx < n && guard < 4000) begin
        check("stream_ready", ready32, 1);
        check("stream_en", en32, exp_en);
        check("stream_w", w32, exp_w);
        check("stream_d", d32, exp_d);
        check("stream_valid_low", rvalid32, 0);
        en_seen += int'(en32);
        if (gap_n < 0) give = ($urandom_range(0, 3) != 0);
        else           give = (gap_cnt >= gap_n);
        if (give) begin
          valid = 1'b1; weight = w_arr[idx]; data = d_arr[idx];
          exp_en = 1'b1; exp_w = w_arr[idx]; exp_d = d_arr[idx];
          idx++; gap_cnt = 0;
        end else begin
          valid = 1'b0; weight = 8'($urandom); data = 8'($urandom);
          exp_en = 1'b0; exp_w = '0; exp_d = '0;
          gap_cnt++;
        end
        @(negedge clk);
        guard++;
      end
      if (guard >= 4000) check("stream_timeout", 1, 0);
      valid = 1'b0;
      check("drain_ready", ready32, 0);
      check("drain_en", en32, 1);
      check("drain_w", w32, exp_w);
      check("drain_d", d32, exp_d);
      check("drain_valid_low", rvalid32, 0);
      en_seen += int'(en32);
      @(negedge clk);
    end

    check("done_valid", rvalid32, 1);
    check("result32", result32, exp32);
    check("result16", result16, exp16);
    check("done_en", en32, 0);
    check("done_w", w32, 0);
    en_seen += int'(en32);
    check("en_count", en_seen, n);

    for (int h = 0; h < hold; h++) begin
      result_ready = 1'b0;
      start = 1'($urandom); len = 8'($urandom);
      @(negedge clk);
      check("hold_valid", rvalid32, 1);
      check("hold_busy", busy32, 1);
      check("hold_result", result32, exp32);
      check("hold_clr", clr32, 0);
    end
    start = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("idle_busy", busy32, 0);
    check("idle_valid", rvalid32, 0);
    check("idle_retain", result32, exp32);
    $display("[TB] job %0d len=%0d gap=%0d hold=%0d result32=%0d result16=%0d",
             job_id, n, gap_n, hold, result32, result16);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; valid = 1'b0;
    weight = '0; data = '0; result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy32, 0);
    check("rst_ready", ready32, 0);
    check("rst_clr", clr32, 0);
    check("rst_en", en32, 0);
    check("rst_w", w32, 0);
    check("rst_d", d32, 0);
    check("rst_result", result32, 0);
    check("rst_valid", rvalid32, 0);
    rst = 1'b0;

    // Basic back-to-back job: 1*2 + 3*4 + 5*6 = 44
    w_arr[0] = 8'd1; d_arr[0] = 8'd2;
    w_arr[1] = 8'd3; d_arr[1] = 8'd4;
    w_arr[2] = 8'd5; d_arr[2] = 8'd6;
    run_job(3, 0, 0);
    // Same pairs with two-cycle bubbles
    run_job(3, 2, 1);
    // Zero length after a nonzero result
    run_job(0, 0, 0);
    // Result backpressure then a fresh LEN=1 job
    w_arr[0] = 8'd9; d_arr[0] = 8'd9;
    run_job(1, 0, 5);
    w_arr[0] = 8'd7; d_arr[0] = 8'd7;
    run_job(1, 0, 0);
    // Wrap: 2*255*255 = 130050, 64514 at 16 bits
    w_arr[0] = 8'd255; d_arr[0] = 8'd255;
    w_arr[1] = 8'd255; d_arr[1] = 8'd255;
    run_job(2, 0, 0);

    // Abort after 2 of 4 pairs
    job_id++;
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; weight = 8'd10 + 8'(i); data = 8'd20;
      @(negedge clk);
    end
    valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy32, 0);
    check("abort_ready", ready32, 0);
    check("abort_clr", clr32, 0);
    check("abort_en", en32, 0);
    check("abort_w", w32, 0);
    check("abort_d", d32, 0);
    check("abort_result", result32, 0);
    check("abort_valid", rvalid32, 0);
    rst = 1'b0;
    $display("[TB] job %0d aborted after 2 of 4 pairs", job_id);
    w_arr[0] = 8'd2; d_arr[0] = 8'd3;
    w_arr[1] = 8'd4; d_arr[1] = 8'd5;
    run_job(2, 0, 0);

    // Random jobs
    for (int j = 0; j < 24; j++) begin
      int n;
      n = $urandom_range(0, 12);
      if (j == 5) n = 40;
      for (int i = 0; i < n; i++) begin
        w_arr[i] = 8'($urandom);
        d_arr[i] = 8'($urandom);
      end
      run_job(n, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 2)),
              $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Stream-side controller that drives a MAC accumulator through one dot-product job. On `i_START` it clears the MAC and accepts `i_LEN` weight/data pairs over a valid/ready stream. It presents each pair to the MAC with a one-cycle enable, then captures the final accumulation and holds it on a valid/ready result port. It sits between the operand fetch logic and the MAC: its `o_MAC_*` outputs connect to the MAC's clear, enable, weight and data inputs, and `i_ACCUMULATE` connects back from the MAC's accumulation output.

## Interface
- `INPUT_WIDTH`, 8, width of weight and data operands
- `OUTPUT_WIDTH`, 32, width of accumulation and result
- `LEN_WIDTH`, 8, width of job length
- `i_CLK`  in  1  clock
- `i_RST`  in  1  reset, synchronous, active-high
- `i_START`  in  1  start job; sampled only in IDLE
- `i_LEN`  in  LEN_WIDTH  pair count, latched with `i_START`
- `o_BUSY`  out  1  high in every state except IDLE
- `i_VALID`  in  1  operand pair valid
- `i_WEIGHT`  in  INPUT_WIDTH  operand weight
- `i_DATA`  in  INPUT_WIDTH  operand data
- `o_READY`  out  1  sequencer accepts the pair this cycle
- `o_MAC_CLR`  out  1  MAC synchronous clear
- `o_MAC_EN`  out  1  MAC accumulate enable
- `o_WEIGHT`  out  INPUT_WIDTH  weight presented to MAC
- `o_DATA`  out  INPUT_WIDTH  data presented to MAC
- `i_ACCUMULATE`  in  OUTPUT_WIDTH  MAC output, defined as combinational registered-sum + `o_WEIGHT`*`o_DATA`
- `o_RESULT`  out  OUTPUT_WIDTH  captured dot product
- `o_RESULT_VALID`  out  1  result available
- `i_RESULT_READY`  in  1  consumer accepts result

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- **IDLE:** `i_START`=1 latches `i_LEN` into the remaining counter and moves to CLEAR. `i_START` in any other state is ignored.
- **CLEAR** (1 cycle):
  - `o_MAC_CLR`=1.
  - If length is 0, go to DONE with `o_RESULT`=0.
  - Otherwise go to STREAM.
- **STREAM:**
  - `o_READY`=1, driven combinationally from state.
  - Accept occurs when `i_VALID`&&`o_READY`.
  - On accept, register `o_WEIGHT`/`o_DATA` from the inputs, set `o_MAC_EN`=1 for the next cycle, and decrement remaining.
  - On a non-accept cycle, register `o_WEIGHT`/`o_DATA`=0 and `o_MAC_EN`=0.
  - Accepting the pair when remaining=1 moves to DRAIN.
- **DRAIN** (1 cycle):
  - `o_READY`=0 and `o_MAC_EN`=1, with the last pair presented.
  - `o_RESULT` <= `i_ACCUMULATE`, which already includes the last product.
  - Go to DONE.
- **DONE:**
  - `o_RESULT_VALID`=1 and `o_RESULT` is held stable.
  - `o_MAC_EN`=0 and operands are 0.
  - `i_RESULT_READY`=1 returns to IDLE on the next edge.
- **Arithmetic:** products and sums wrap modulo 2^OUTPUT_WIDTH (MAC behaviour); the sequencer adds no saturation. Operands are unsigned.
- `o_RESULT` retains its value in IDLE until the next capture or reset.

## Timing
- **Reset:** state IDLE. All outputs are 0: `o_BUSY`, `o_READY`, `o_MAC_CLR`, `o_MAC_EN`, `o_WEIGHT`, `o_DATA`, `o_RESULT`, `o_RESULT_VALID`.
- **Reset mid-job:** aborts the job with no result. The MAC is not cleared by the sequencer; the next job's CLEAR handles it.
- **Job start:** `i_START` at cycle k gives `o_MAC_CLR`=1 at k+1 and `o_READY`=1 from k+2.
  - For length 0, `o_RESULT_VALID`=1 at k+2.
- **Throughput:** one pair per cycle with `i_VALID` held high; bubbles on `i_VALID` produce `o_MAC_EN`=0 cycles.
- **Result timing:** the last accept at cycle m gives DRAIN at m+1 and `o_RESULT_VALID`=1 at m+2. For N back-to-back pairs from k+2, the result is valid at k+N+3.
- **Earliest restart:** `i_RESULT_READY` high while in DONE returns to IDLE; the earliest new `i_START` is accepted the cycle after.

## Test plan
- **Basic job:** LEN=3, pairs (1,2),(3,4),(5,6) back-to-back, with a behavioural MAC attached. Required: `o_RESULT`=44, `o_RESULT_VALID` at start+6, and `o_MAC_EN` high for exactly 3 cycles.
- **Bubbles:** same pairs with `i_VALID` low for 2 cycles between each pair. Required: `o_RESULT`=44, `o_MAC_EN` never high during a bubble, and result valid 2 cycles after the last accept.
- **Zero length:** LEN=0. Required: one `o_MAC_CLR` pulse, no `o_READY`, `o_RESULT`=0 valid at start+2.
- **Result backpressure:** hold `i_RESULT_READY`=0 for 5 cycles. Required:
  - `o_RESULT` and `o_RESULT_VALID` stay stable.
  - `i_START` is ignored and `o_BUSY` stays 1.
  - After ready, IDLE and a second job (LEN=1, (7,7)) gives 49, with no carry-over from the first job.
- **Wrap:** OUTPUT_WIDTH=16, LEN=2, pairs (255,255),(255,255). Required: `o_RESULT`=64514.
- **Abort:** `i_RST` asserted after 2 of 4 pairs. Required: all outputs 0 next cycle and no result. The following job LEN=2, (2,3),(4,5) gives 26.
